// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD demo sequencer.
//   mode_e  : operating mode encoding driven on the mode input
//   state_e : sequencer phase, face sweep or channel sweep
//   w_min1  : width helper that keeps derived vector widths at least 1 bit
package lcd_seq_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_AUTO      = 2'd0,
        MODE_STEP      = 2'd1,
        MODE_HOLD      = 2'd2,
        MODE_FACE_ONLY = 2'd3
    } mode_e;

    typedef enum logic {
        S_FACE = 1'b0,
        S_CHAN = 1'b1
    } state_e;

    function automatic int w_min1(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lcd_demo_sequencer_if.sv
// Control/display bundle between the demo sequencer and its user.
//   mode, step, pause       : control, driven by the master side
//   face, values            : registered display state, channel 0 in values LSBs
//   update, seq_done        : one-cycle pulses from the sequencer
// slave modport is the sequencer, master modport is whoever drives it.
interface lcd_demo_sequencer_if
    import lcd_seq_pkg::*;
#(
    parameter int FACE_W       = 4,
    parameter int VAL_W        = 3,
    parameter int NUM_CHANNELS = 3
);
    logic [MODE_W-1:0]             mode;
    logic                          step;
    logic                          pause;
    logic [FACE_W-1:0]             face;
    logic [NUM_CHANNELS*VAL_W-1:0] values;
    logic                          update;
    logic                          seq_done;

    modport master (
        output mode, step, pause,
        input  face, values, update, seq_done
    );

    modport slave (
        input  mode, step, pause,
        output face, values, update, seq_done
    );
endinterface

// File: rtl/lcd_seq_tick.sv
// Dwell timer: counts enabled cycles over 0..DWELL-1 and flags the last one.
//   clk, reset : clock and asynchronous active-low reset
//   en         : count enable; when low the count is held, not cleared
//   tick       : high in the enabled cycle where the count is DWELL-1
module lcd_seq_tick
    import lcd_seq_pkg::*;
#(
    parameter int DWELL = 64000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int                CNT_W    = w_min1($clog2(DWELL));
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Combinational so the advance lands on the same edge the count wraps.
    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lcd_demo_sequencer.sv
// LCD demo sequencer: sweeps face codes, then sweeps each status channel
// from 0 to MAX_VALUE in turn, then wraps. Advances come from the dwell
// timer (AUTO/FACE_ONLY) or the step input (STEP); HOLD freezes everything.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : slave side of lcd_demo_sequencer_if (mode/step/pause in,
//                face/values/update/seq_done out, all outputs registered)
module lcd_demo_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int NUM_FACES    = 9,
    parameter int MAX_VALUE    = 5,
    parameter int NUM_CHANNELS = 3,
    parameter int DWELL        = 64000000
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_demo_sequencer_if.slave  bus
);
    localparam int FACE_W = w_min1($clog2(NUM_FACES));
    localparam int VAL_W  = w_min1($clog2(MAX_VALUE + 1));
    localparam int CH_W   = w_min1($clog2(NUM_CHANNELS));

    localparam logic [FACE_W-1:0] FACE_LAST = FACE_W'(NUM_FACES - 1);
    localparam logic [VAL_W-1:0]  VAL_MAX   = VAL_W'(MAX_VALUE);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CHANNELS - 1);

    state_e                               state_q, state_d;
    logic [CH_W-1:0]                      ch_q, ch_d;
    logic [FACE_W-1:0]                    face_q, face_d;
    logic [NUM_CHANNELS-1:0][VAL_W-1:0]   vals_q, vals_d;
    logic                                 update_q, update_d;
    logic                                 seq_done_q, seq_done_d;

    mode_e            mode;
    logic             tick_en, tick, advance, face_only;
    logic [VAL_W-1:0] cur_val;

    assign mode      = mode_e'(bus.mode);
    assign face_only = (mode == MODE_FACE_ONLY);
    assign tick_en   = ((mode == MODE_AUTO) || face_only) && !bus.pause;
    assign cur_val   = vals_q[ch_q];

    lcd_seq_tick #(.DWELL(DWELL)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .tick  (tick)
    );

    always_comb begin
        unique case (mode)
            MODE_AUTO, MODE_FACE_ONLY: advance = tick;
            MODE_STEP:                 advance = bus.step;
            default:                   advance = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        face_d     = face_q;
        vals_d     = vals_q;
        update_d   = advance;
        seq_done_d = 1'b0;
        if (advance) begin
            unique case (state_q)
                S_FACE: begin
                    if (face_q < FACE_LAST) begin
                        face_d = face_q + 1'b1;
                    end else if (face_only) begin
                        face_d = '0;
                    end else begin
                        ch_d      = '0;
                        vals_d[0] = '0;
                        state_d   = S_CHAN;
                    end
                end
                S_CHAN: begin
                    if (face_only) begin
                        // Abandon the channel sweep and go straight back to faces.
                        vals_d  = {NUM_CHANNELS{VAL_MAX}};
                        face_d  = '0;
                        state_d = S_FACE;
                    end else if (cur_val < VAL_MAX) begin
                        vals_d[ch_q] = cur_val + 1'b1;
                    end else if (ch_q < CH_LAST) begin
                        ch_d         = ch_q + 1'b1;
                        vals_d[ch_d] = '0;
                    end else begin
                        // Every channel already sits at MAX_VALUE here.
                        face_d     = '0;
                        state_d    = S_FACE;
                        seq_done_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FACE;
            ch_q       <= '0;
            face_q     <= '0;
            vals_q     <= {NUM_CHANNELS{VAL_MAX}};
            update_q   <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            face_q     <= face_d;
            vals_q     <= vals_d;
            update_q   <= update_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign bus.face     = face_q;
    assign bus.values   = vals_q;
    assign bus.update   = update_q;
    assign bus.seq_done = seq_done_q;
endmodule

// File: tb/tb_lcd_demo_sequencer.sv
// Self-checking bench for lcd_demo_sequencer with a position-based model:
// the whole sequence is a single index p in 0..PERIOD-1 from which face and
// channel values are derived arithmetically.
module tb_lcd_demo_sequencer;
    import lcd_seq_pkg::*;

    localparam int NF     = 3;
    localparam int MV     = 2;
    localparam int NC     = 2;
    localparam int DW     = 4;
    localparam int FW     = w_min1($clog2(NF));
    localparam int VW     = w_min1($clog2(MV + 1));
    localparam int PERIOD = NF + NC * (MV + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lcd_demo_sequencer_if #(.FACE_W(FW), .VAL_W(VW), .NUM_CHANNELS(NC)) bus ();

    lcd_demo_sequencer #(
        .NUM_FACES(NF), .MAX_VALUE(MV), .NUM_CHANNELS(NC), .DWELL(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int p;
        int cnt;
        bit upd;
        bit done;
    } mstate_t;

    mstate_t m = '{p: 0, cnt: 0, upd: 1'b0, done: 1'b0};

    function automatic mstate_t model_next(mstate_t s, logic [1:0] md, logic stp, logic ps);
        mstate_t n;
        bit adv;
        n = s;
        adv = 1'b0;
        n.done = 1'b0;
        if ((md == MODE_AUTO || md == MODE_FACE_ONLY) && !ps) begin
            if (s.cnt == DW - 1) begin n.cnt = 0; adv = 1'b1; end
            else n.cnt = s.cnt + 1;
        end else if (md == MODE_STEP && stp) begin
            adv = 1'b1;
        end
        n.upd = adv;
        if (adv) begin
            if (md == MODE_FACE_ONLY)     n.p = (s.p < NF - 1) ? s.p + 1 : 0;
            else if (s.p == PERIOD - 1) begin n.p = 0; n.done = 1'b1; end
            else                          n.p = s.p + 1;
        end
        return n;
    endfunction

    function automatic int exp_face(int pp);
        return (pp < NF) ? pp : NF - 1;
    endfunction

    function automatic logic [NC*VW-1:0] exp_vals(int pp);
        logic [NC*VW-1:0] v;
        for (int c = 0; c < NC; c++) begin
            int val;
            val = MV;
            if (pp >= NF && (pp - NF) / (MV + 1) == c) val = (pp - NF) % (MV + 1);
            v[c*VW +: VW] = VW'(val);
        end
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{p: 0, cnt: 0, upd: 1'b0, done: 1'b0};
        else        m <= model_next(m, bus.mode, bus.step, bus.pause);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("face",     bus.face,     exp_face(m.p));
        check("values",   bus.values,   exp_vals(m.p));
        check("update",   bus.update,   m.upd);
        check("seq_done", bus.seq_done, m.done);
    end

    // ---------------- stimulus ----------------
    int nu, nd, n;
    logic [FW-1:0]    f_save;
    logic [NC*VW-1:0] v_save;

    task automatic cyc(input int k);
        repeat (k) begin
            @(negedge clk);
            nu += int'(bus.update);
            nd += int'(bus.seq_done);
        end
    endtask

    initial begin
        bus.mode  = MODE_AUTO;
        bus.step  = 1'b0;
        bus.pause = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_face",   bus.face,     0);
        check("rst_values", bus.values,   4'b1010);
        check("rst_update", bus.update,   0);
        check("rst_done",   bus.seq_done, 0);

        // AUTO: one full period in 36 cycles
        reset = 1'b1;
        nu = 0; nd = 0;
        cyc(36);
        check("auto_updates", nu, 9);
        check("auto_done",    nd, 1);
        check("auto_face",    bus.face, 0);

        // STEP: three pulses spaced 5 cycles
        bus.mode = MODE_STEP;
        nu = 0; nd = 0;
        for (int k = 0; k < 3; k++) begin
            bus.step = 1'b1; cyc(1);
            bus.step = 1'b0; cyc(4);
        end
        check("step_updates", nu, 3);
        check("step_face",    bus.face, 2);
        check("step_values",  bus.values, 4'b1000);

        // AUTO with pause at dwell count 2
        bus.mode = MODE_AUTO;
        cyc(2);
        bus.pause = 1'b1;
        nu = 0;
        cyc(10);
        check("pause_no_update", nu, 0);
        bus.pause = 1'b0;
        n = 0;
        do begin cyc(1); n++; end while (!bus.update && n < 20);
        check("pause_resume_lat", n, 2);
        check("pause_vals", bus.values, 4'b1001);

        // FACE_ONLY entered mid channel sweep
        bus.mode = MODE_FACE_ONLY;
        n = 0;
        do begin cyc(1); n++; end while (!bus.update && n < 20);
        check("fo_lat",    n, 4);
        check("fo_face",   bus.face, 0);
        check("fo_values", bus.values, 4'b1010);
        nu = 0; nd = 0;
        cyc(12);
        check("fo_updates", nu, 3);
        check("fo_done",    nd, 0);
        check("fo_face_end", bus.face, 0);

        // Step held high for 4 cycles gives 4 advances, then async reset
        bus.mode = MODE_STEP;
        nu = 0;
        bus.step = 1'b1; cyc(4); bus.step = 1'b0;
        check("hold_step_updates", nu, 4);
        check("hold_step_values",  bus.values, 4'b1001);
        bus.mode = MODE_AUTO;
        #2 reset = 1'b0;
        #1;
        check("async_face",   bus.face, 0);
        check("async_values", bus.values, 4'b1010);
        @(negedge clk);
        #2 reset = 1'b1;
        n = 0;
        do begin cyc(1); n++; end while (!bus.update && n < 20);
        check("post_rst_lat", n, 4);

        // HOLD with step toggling
        bus.mode = MODE_HOLD;
        f_save = bus.face; v_save = bus.values;
        nu = 0; nd = 0;
        for (int k = 0; k < 20; k++) begin
            bus.step = ~bus.step;
            cyc(1);
        end
        check("hold_face",    bus.face, f_save);
        check("hold_values",  bus.values, v_save);
        check("hold_updates", nu, 0);
        check("hold_done",    nd, 0);

        // Randomized traffic checked by the per-cycle compare
        bus.step = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
            bus.step  = ($urandom_range(0, 2) == 0);
            bus.pause = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
